// File: rtl/display_pkg.sv
// Shared state encoding and digit-selection helpers for the display scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam int DIGITS = 4;

  // First set bit above cur, wrapping 3->0; falls back to cur when it is the only one set.
  function automatic logic [1:0] next_digit(input logic [3:0] mask, input logic [1:0] cur);
    logic [1:0] idx;
    logic [1:0] res;
    logic found;
    res = cur;
    found = 1'b0;
    for (int i = 1; i <= DIGITS; i++) begin
      idx = cur + 2'(i);
      if (!found && mask[idx]) begin
        res = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] an_for(input logic [1:0] d, input logic lit);
    logic [3:0] v;
    v = 4'hF;
    if (lit) v[d] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-N cycle counter with synchronous clear; tc is high while the count sits at N-1.
module scan_prescaler #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] count;

  assign tc = (count == W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment refresh controller: one digit lit at a time, DIV cycles each.
// DISPLAY_SCAN_GUARD_EN adds GUARD dark cycles between digits so the segment mux settles unlit.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] en_mask,
  output logic [1:0] Sel,
  output logic [3:0] AN,
  output logic       frame_start
);

  state_t     state;
  logic       dwell_tc;
  logic [1:0] nxt;
  logic [1:0] first;

  assign nxt   = next_digit(en_mask, Sel);
  assign first = next_digit(en_mask, 2'd3);

  scan_prescaler #(.N(DIV)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr ((state != ST_SHOW) || (en_mask == 4'd0)),
    .en  (state == ST_SHOW),
    .tc  (dwell_tc)
  );

`ifdef DISPLAY_SCAN_GUARD_EN
  logic guard_tc;
  logic wrap_q;

  scan_prescaler #(.N(GUARD)) u_guard (
    .clk (clk),
    .rst (rst),
    .clr ((state != ST_GUARD) || (en_mask == 4'd0)),
    .en  (state == ST_GUARD),
    .tc  (guard_tc)
  );
`else
  localparam int unused_guard = GUARD;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      Sel         <= 2'd0;
      AN          <= 4'hF;
      frame_start <= 1'b0;
`ifdef DISPLAY_SCAN_GUARD_EN
      wrap_q      <= 1'b0;
`endif
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          AN <= 4'hF;
          if (en_mask != 4'd0) begin
            state       <= ST_SHOW;
            Sel         <= first;
            AN          <= an_for(first, 1'b1);
            frame_start <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (en_mask == 4'd0) begin
            state <= ST_IDLE;
            AN    <= 4'hF;
          end else if (dwell_tc) begin
            Sel <= nxt;
`ifdef DISPLAY_SCAN_GUARD_EN
            // Advance the mux while dark; the frame pulse waits for the digit to light.
            state  <= ST_GUARD;
            AN     <= 4'hF;
            wrap_q <= (nxt <= Sel);
`else
            AN          <= an_for(nxt, 1'b1);
            frame_start <= (nxt <= Sel);
`endif
          end else begin
            AN <= an_for(Sel, en_mask[Sel]);
          end
        end
`ifdef DISPLAY_SCAN_GUARD_EN
        ST_GUARD: begin
          AN <= 4'hF;
          if (en_mask == 4'd0) begin
            state <= ST_IDLE;
          end else if (guard_tc) begin
            state       <= ST_SHOW;
            AN          <= an_for(Sel, en_mask[Sel]);
            frame_start <= wrap_q;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          AN    <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIV=4, GUARD=2), either build of the guard option.
module tb_display_scan_ctrl;

  localparam int DIVP = 4;
`ifdef DISPLAY_SCAN_GUARD_EN
  localparam int GC = 2;
`else
  localparam int GC = 0;
`endif
  localparam int P = DIVP + GC;

  logic       clk;
  logic       rst;
  logic [3:0] en_mask;
  logic [1:0] Sel;
  logic [3:0] AN;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(.DIV(4), .GUARD(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_mask     (en_mask),
    .Sel         (Sel),
    .AN          (AN),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the digit period, counted from the first lit cycle.
  bit         m_act;
  int         m_sel;
  int         m_t;
  logic [3:0] m_an;
  bit         m_fs;
  bit         m_pend;

  function automatic int next_set(input logic [3:0] m, input int cur);
    for (int k = 1; k <= 4; k++) begin
      if (m[(cur + k) % 4]) return (cur + k) % 4;
    end
    return cur;
  endfunction

  function automatic logic [3:0] lit(input int d);
    logic [3:0] v;
    v = 4'hF;
    v[d] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_act = 0; m_sel = 0; m_t = 0; m_an = 4'hF; m_fs = 0; m_pend = 0;
  endtask

  task automatic model_step(input logic [3:0] m);
    int nd;
    m_fs = 0;
    if (!m_act) begin
      m_an = 4'hF;
      if (m != 4'd0) begin
        m_act = 1; m_sel = next_set(m, 3); m_t = 0; m_fs = 1; m_an = lit(m_sel);
      end
    end else if (m == 4'd0) begin
      m_act = 0; m_an = 4'hF;
    end else if (m_t == DIVP - 1) begin
      nd = next_set(m, m_sel);
      m_pend = (nd <= m_sel);
      m_sel = nd;
      if (GC == 0) begin
        m_t = 0; m_fs = m_pend; m_an = lit(nd);
      end else begin
        m_t = DIVP; m_an = 4'hF;
      end
    end else if (m_t >= DIVP) begin
      if (m_t == P - 1) begin
        m_t = 0; m_fs = m_pend; m_an = m[m_sel] ? lit(m_sel) : 4'hF;
      end else begin
        m_t++; m_an = 4'hF;
      end
    end else begin
      m_t++;
      m_an = m[m_sel] ? lit(m_sel) : 4'hF;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".Sel"}, {2'b00, Sel}, 4'(m_sel));
    chk({tag, ".AN"}, AN, m_an);
    chk({tag, ".frame_start"}, {3'b000, frame_start}, {3'b000, m_fs});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_step(en_mask);
    #1;
    chk_model(tag);
  endtask

  task automatic hold_reset(input logic [3:0] m);
    rst = 1'b1;
    en_mask = m;
    #1;
    model_reset();
    chk_model("reset");
    tick("reset_hold");
    rst = 1'b0;
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [1:0] sel;
    logic [3:0] an;
    logic       fs;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    tbl[0] = '{0,           4'hF, 2'd0, 4'b1110, 1'b1};
    tbl[1] = '{DIVP - 1,    4'hF, 2'd0, 4'b1110, 1'b0};
    tbl[2] = '{DIVP,        4'hF, 2'd1, (GC > 0) ? 4'b1111 : 4'b1101, 1'b0};
    tbl[3] = '{P,           4'hF, 2'd1, 4'b1101, 1'b0};
    tbl[4] = '{2 * P,       4'hF, 2'd2, 4'b1011, 1'b0};
    tbl[5] = '{3 * P + 3,   4'hF, 2'd3, 4'b0111, 1'b0};
    tbl[6] = '{4 * P,       4'hF, 2'd0, 4'b1110, 1'b1};
    tbl[7] = '{4 * P + 1,   4'hF, 2'd0, 4'b1110, 1'b0};

    // Reset state with all digits enabled.
    rst = 1'b1;
    en_mask = 4'hF;
    #1;
    model_reset();
    chk("rst.Sel", {2'b00, Sel}, 4'd0);
    chk("rst.AN", AN, 4'b1111);
    chk("rst.frame_start", {3'b000, frame_start}, 4'd0);

    // Full scan from reset release, table-driven.
    hold_reset(tbl[0].mask);
    idx = 0;
    for (int c = 0; c <= 4 * P + 1; c++) begin
      tick("scan");
      while (idx < 8 && tbl[idx].cyc == c) begin
        chk("tbl.Sel", {2'b00, Sel}, {2'b00, tbl[idx].sel});
        chk("tbl.AN", AN, tbl[idx].an);
        chk("tbl.frame_start", {3'b000, frame_start}, {3'b000, tbl[idx].fs});
        idx++;
        if (idx < 8) en_mask = tbl[idx].mask;
      end
    end

    // Sparse mask: digits 1 and 3 alternate.
    hold_reset(4'b1010);
    tick("sparse");
    chk("sparse.first.Sel", {2'b00, Sel}, 4'd1);
    chk("sparse.first.AN", AN, 4'b1101);
    chk("sparse.first.fs", {3'b000, frame_start}, 4'd1);
    for (int c = 0; c < 6 * P; c++) tick("sparse");

    // Mask drop at prescaler=1 of digit 2, then restore digit 2 alone.
    hold_reset(4'hF);
    for (int c = 0; c <= 2 * P + 1; c++) tick("drop_pre");
    en_mask = 4'b0000;
    tick("drop");
    chk("drop.Sel", {2'b00, Sel}, 4'd2);
    chk("drop.AN", AN, 4'b1111);
    chk("drop.fs", {3'b000, frame_start}, 4'd0);
    en_mask = 4'b0100;
    tick("restore");
    chk("restore.Sel", {2'b00, Sel}, 4'd2);
    chk("restore.AN", AN, 4'b1011);
    chk("restore.fs", {3'b000, frame_start}, 4'd1);
    for (int c = 0; c < 3 * P; c++) tick("single");

    // Asynchronous reset in the first cycle after the dwell (guard cycle when enabled).
    hold_reset(4'hF);
    for (int c = 0; c <= DIVP; c++) tick("pre_mid_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.Sel", {2'b00, Sel}, 4'd0);
    chk("midrst.AN", AN, 4'b1111);
    chk("midrst.fs", {3'b000, frame_start}, 4'd0);
    model_reset();
    tick("midrst_hold");
    rst = 1'b0;
    tick("restart");
    chk("restart.Sel", {2'b00, Sel}, 4'd0);
    chk("restart.AN", AN, 4'b1110);
    chk("restart.fs", {3'b000, frame_start}, 4'd1);

    // Randomised mask changes and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        hold_reset(4'($urandom_range(0, 15)));
      end else if ($urandom_range(0, 15) == 0) begin
        en_mask = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed refresh controller for the four-digit 7-segment display. It drives the 2-bit select bus of the shared 7-bit segment multiplexer and the active-low digit (anode) enables. Only one digit is lit at a time, and the controller cycles through the enabled digits at a fixed dwell rate. It sits between the system clock domain and the board display: the segment data passes through the multiplexer, and this block decides which digit that data belongs to.

## Interface
- `DIV`, default 50000: clock cycles each digit is lit (SHOW dwell). Must be ≥ 2.
- `GUARD`, default 16: blanking cycles between digits. Used only with the macro; must be ≥ 1 when the macro is used.
- `clk`, input, 1: system clock. Everything is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en_mask`, input, 4: digit enables. Bit i=1 means digit i takes part in the scan.
- `Sel`, output, 2: select for the segment multiplexer. Registered.
- `AN`, output, 4: active-low digit enables. Registered. At most one bit is low.
- `frame_start`, output, 1: one-cycle pulse when a new scan frame begins.

## Operation
- Reset values: state IDLE, `Sel`=0, `AN`=4'b1111, `frame_start`=0, prescaler=0.
- States: IDLE, SHOW, GUARD (GUARD exists only with the macro).
- IDLE
  - `AN`=1111 and `Sel` holds.
  - When `en_mask`≠0, go to SHOW next edge: `Sel` = lowest set bit of `en_mask`, `AN` low on that bit, `frame_start`=1, prescaler=0.
- SHOW
  - `AN` = ~onehot(`Sel`), gated by `en_mask[Sel]`. If the current digit's bit is cleared mid-dwell, `AN`=1111 from the next edge.
  - Prescaler counts 0..DIV-1.
  - At DIV-1 the next digit is computed: first set bit of `en_mask` scanning upward from `Sel`+1, wrapping 3→0. If only the current bit is set, the next digit is the current digit.
- Digit change
  - `Sel` updates to the next digit and the prescaler clears on the same edge.
  - `frame_start` pulses for one cycle when next index ≤ current index (wrap or single digit).
- Mask cleared: `en_mask`=0 in SHOW or GUARD → IDLE on the next edge, `AN`=1111, `Sel` holds.
- `en_mask` is sampled only at the boundary when choosing the next digit and for the current-digit gating. No other mask change has any effect.

## Timing
- Reset release to first lit digit: 1 cycle, provided `en_mask`≠0.
- Without the macro, digit period = DIV cycles, and `Sel` and `AN` change on the same edge.
- With the macro, digit period = DIV + GUARD cycles: DIV cycles lit, then GUARD cycles with `AN`=1111.
- Frame period = (number of enabled digits) × digit period.
- `frame_start` is high exactly one cycle per frame, aligned with the first lit cycle of the frame's first digit.
- Reset mid-operation forces the reset values immediately, asynchronously, in any state.

## Configuration
- Macro: `DISPLAY_SCAN_GUARD_EN`.
- Defined:
  - At the end of the SHOW dwell, go to GUARD. `Sel` takes the next digit on entry (so the multiplexer settles while dark) and `AN`=1111.
  - After GUARD cycles, return to SHOW with `AN` asserted on the new `Sel`.
  - `frame_start` is asserted on that GUARD→SHOW edge.
  - Purpose: removes ghosting.
- Undefined: no GUARD state and the `GUARD` parameter is ignored. SHOW→SHOW directly.

## Structure
- Package `display_pkg`:
  - state encoding (IDLE, SHOW, GUARD);
  - constant `DIGITS`=4;
  - function `next_digit(mask, cur)` returning the wrapped next set index.
- Sub-module `scan_prescaler`: parameterised modulo-N counter with clear input and terminal-count output. Used for both the SHOW dwell and the GUARD count.

## Test plan
All scenarios use DIV=4, GUARD=2.
- Reset and startup: `rst`=1 with `en_mask`=1111 → `Sel`=0, `AN`=1111. First edge after release → `Sel`=0, `AN`=1110, `frame_start`=1.
- Full scan, macro off: `en_mask`=1111 → `Sel` runs 0,1,2,3,0, each held 4 cycles. `AN` = 1110, 1101, 1011, 0111. `frame_start` every 16 cycles.
- Guard, macro on: `en_mask`=1111 → each digit gives 4 cycles lit, then 2 cycles `AN`=1111 with `Sel` already advanced. Period 6, frame 24.
- Sparse mask: `en_mask`=1010 → `Sel` alternates 1,3 and `AN` alternates 1101, 0111. `frame_start` on each 3→1 change.
- Mask drop and restore: `en_mask`→0 at prescaler=1 of digit 2 → next edge `AN`=1111, IDLE, `Sel`=2. Then `en_mask`=0100 → `Sel`=2, `AN`=1011, `frame_start`=1.
- Reset mid-GUARD: `rst` pulsed during guard cycle 1 → `AN`=1111 and `Sel`=0 immediately. Restart as in the first scenario.
